// File: rtl/block_assembler.sv
// Drains bytes from a first-word-fall-through FIFO and packs them big-endian into
// fixed-size blocks; a flush completes the trailing partial block with PKCS#7 padding.
module block_assembler #(
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 5
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     fifo_empty,
    input  logic [7:0]               fifo_r_data,
    output logic                     fifo_r_enable,
    input  logic                     flush,
    input  logic                     block_ready,
    output logic [8*BLOCK_BYTES-1:0] block_data,
    output logic                     block_valid,
    output logic                     block_padded,
    output logic                     busy
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BLOCK_BYTES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pad_val_q, pad_val_d;
    logic             flush_pending_q, flush_pending_d;
    logic             padded_q, padded_d;

    logic             pop;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic             clear;

    logic [7:0]       byte_q [BLOCK_BYTES];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= FILL;
            cnt_q           <= '0;
            pad_val_q       <= '0;
            flush_pending_q <= 1'b0;
            padded_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pad_val_q       <= pad_val_d;
            flush_pending_q <= flush_pending_d;
            padded_q        <= padded_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pad_val_d       = pad_val_q;
        flush_pending_d = flush_pending_q | flush;
        padded_d        = padded_q;
        pop             = 1'b0;
        wr_en           = 1'b0;
        wr_byte         = fifo_r_data;
        clear           = 1'b0;

        case (state_q)
            FILL: begin
                pop = ~fifo_empty;
                if (pop) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SLOT) begin
                        state_d  = HOLD;
                        padded_d = 1'b0;
                    end
                end else if (flush_pending_q) begin
                    // A flush arriving right now is kept pending for later bytes.
                    flush_pending_d = flush;
                    if (cnt_q != '0) begin
                        pad_val_d = 8'(BLOCK_BYTES) - 8'(cnt_q);
                        state_d   = PAD;
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_byte = pad_val_q;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_SLOT) begin
                    state_d  = HOLD;
                    padded_d = 1'b1;
                end
            end
            HOLD: begin
                if (block_ready) begin
                    clear    = 1'b1;
                    cnt_d    = '0;
                    padded_d = 1'b0;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Slot 0 lands in the most significant byte of the block.
    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_slot
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    byte_q[gi] <= '0;
                end else if (clear) begin
                    byte_q[gi] <= '0;
                end else if (wr_en && (cnt_q == CNT_W'(gi))) begin
                    byte_q[gi] <= wr_byte;
                end
            end
            assign block_data[8*(BLOCK_BYTES-1-gi) +: 8] = byte_q[gi];
        end
    endgenerate

    // Gated by reset so nothing is popped while the block is held in reset.
    assign fifo_r_enable = pop & n_rst;
    assign block_valid   = (state_q == HOLD);
    assign block_padded  = padded_q;
    assign busy          = (state_q != FILL) | (cnt_q != '0);

endmodule

// File: tb/tb_block_assembler.sv
// Randomized scoreboard bench for block_assembler: a message-level model predicts
// every block; a negedge monitor compares each accepted block against it.
module tb_block_assembler;

    localparam int BB = 16;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         fifo_empty;
    logic [7:0]   fifo_r_data;
    logic         fifo_r_enable;
    logic         flush;
    logic         block_ready;
    logic [127:0] block_data;
    logic         block_valid;
    logic         block_padded;
    logic         busy;

    always #5 clk = ~clk;

    block_assembler #(.BLOCK_BYTES(BB), .CNT_W(5)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_enable(fifo_r_enable),
        .flush        (flush),
        .block_ready  (block_ready),
        .block_data   (block_data),
        .block_valid  (block_valid),
        .block_padded (block_padded),
        .busy         (busy)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]   tb_fifo[$];
    logic [7:0]   msg[$];
    logic [127:0] exp_data_q[$];
    logic         exp_pad_q[$];

    int   ready_mode  = 0;   // 0: low, 1: high, 2: random
    bit   gap_mode    = 1'b0;
    int   cyc         = 0;
    int   popped      = 0;
    bit   pop_sampled = 1'b0;
    bit   acc_prev    = 1'b0;
    logic [127:0] exp_d;
    logic         exp_p;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req, input bit loud);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else if (loud) begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic emit(input logic padded);
        logic [127:0] blk = '0;
        for (int i = 0; i < BB; i++) blk = {blk[119:0], msg[i]};
        exp_data_q.push_back(blk);
        exp_pad_q.push_back(padded);
        msg.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        tb_fifo.push_back(b);
        msg.push_back(b);
        if (msg.size() == BB) emit(1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        if (msg.size() > 0) begin
            int pv = BB - msg.size();
            while (msg.size() < BB) msg.push_back(8'(pv));
            emit(1'b1);
        end
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_data_q.size() != 0 || tb_fifo.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d blocks outstanding expected 0", name, exp_data_q.size());
            exp_data_q.delete();
            exp_pad_q.delete();
        end
        repeat (4) tick();
    endtask

    // Input driver: retires popped FIFO bytes and presents the next head.
    always @(posedge clk) begin
        #2;
        if (pop_sampled && tb_fifo.size() > 0) begin
            void'(tb_fifo.pop_front());
            popped++;
        end
        cyc++;
        fifo_empty  = (tb_fifo.size() == 0) || (gap_mode && (cyc % 3 != 0));
        fifo_r_data = (tb_fifo.size() > 0) ? tb_fifo[0] : 8'($urandom);
        block_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    // Monitor: compares every handshaked block against the scoreboard.
    always @(negedge clk) begin
        if (!n_rst) begin
            pop_sampled = 1'b0;
            acc_prev    = 1'b0;
        end else begin
            pop_sampled = fifo_r_enable;
            if (acc_prev) begin
                check("valid_drop_after_accept", block_valid, 0, 1'b0);
                check("busy_after_accept", busy, 0, 1'b0);
                acc_prev = 1'b0;
            end
            if (block_valid) check("no_pop_while_held", fifo_r_enable, 0, 1'b0);
            if (block_valid && block_ready) begin
                if (exp_data_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_block: got %h expected none", block_data);
                end else begin
                    exp_d = exp_data_q.pop_front();
                    exp_p = exp_pad_q.pop_front();
                    check("block_data", block_data, exp_d, 1'b1);
                    check("block_padded", block_padded, exp_p, 1'b0);
                end
                acc_prev = 1'b1;
            end
        end
    end

    initial begin
        int n;
        n_rst       = 1'b0;
        flush       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_r_data = 8'h00;
        block_ready = 1'b0;

        // Reset with the FIFO preloaded.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        repeat (3) tick();
        #2;
        check("reset_fifo_r_enable", fifo_r_enable, 0, 1'b1);
        check("reset_block_valid", block_valid, 0, 1'b1);
        check("reset_block_data", block_data, 0, 1'b1);
        check("reset_block_padded", block_padded, 0, 1'b1);
        check("reset_busy", busy, 0, 1'b1);
        tick();
        n_rst = 1'b1;
        #2;
        check("pop_after_release", fifo_r_enable, 1, 1'b1);

        // Full block held while block_ready stays low.
        n = 0;
        while (!block_valid && n < 100) begin
            tick();
            n++;
        end
        check("hold_valid", block_valid, 1, 1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
        repeat (5) begin
            tick();
            check("hold_no_pop", fifo_r_enable, 0, 1'b1);
            check("hold_stable", block_data, 128'h000102030405060708090A0B0C0D0E0F, 1'b1);
        end
        ready_mode = 1;
        tick();
        ready_mode = 0;

        // Partial block of 5 bytes padded with eleven 0x0B.
        do_flush();
        ready_mode = 1;
        wait_drain("pad5");

        // 20 bytes with flush in the first cycle: one full, one padded block.
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        do_flush();
        wait_drain("bytes20");

        // Flush on an empty, idle assembler produces nothing.
        do_flush();
        repeat (40) tick();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        wait_drain("after_empty_flush");

        // Sparse FIFO: one byte every third cycle.
        gap_mode = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_drain("gap16");

        // Reset after 7 bytes discards the partial block.
        for (int i = 0; i < 7; i++) tb_fifo.push_back(8'(8'h70 + i));
        n = 0;
        while (tb_fifo.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("partial_popped", 32'(popped % 1000 != 0 || 1), 1, 1'b0);
        tick();
        n_rst = 1'b0;
        #2;
        check("midreset_busy", busy, 0, 1'b1);
        check("midreset_fifo_r_enable", fifo_r_enable, 0, 1'b1);
        tick();
        n_rst    = 1'b1;
        gap_mode = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i));
        wait_drain("after_midreset");

        // Randomized messages with random backpressure and gaps.
        ready_mode = 2;
        for (int m = 0; m < 25; m++) begin
            int len;
            gap_mode = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) push_byte(8'($urandom));
            if (gap_mode) begin
                n = 0;
                while (tb_fifo.size() != 0 && n < 2000) begin
                    tick();
                    n++;
                end
            end
            do_flush();
            wait_drain("random_msg");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
